// File: rtl/z_pkg.sv
// rtl/z_pkg.sv - shared constants and packer state type for the z-pair packer
package z_pkg;

    localparam int WORD_W             = 8;
    localparam int PAIRS_PER_WORD     = 4;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    typedef enum logic {
        EMPTY   = 1'b0,
        PARTIAL = 1'b1
    } pack_state_t;

endpackage

// File: rtl/z_packer_if.sv
// rtl/z_packer_if.sv - pair capture and packed-word output handshake bundle
interface z_packer_if;
    import z_pkg::*;

    logic              in_valid;
    logic              z1;
    logic              z2;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;

    modport master (
        output in_valid, z1, z2, flush, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  in_valid, z1, z2, flush, out_ready,
        output out_valid, out_data
    );

endinterface

// File: rtl/z_sync_fifo.sv
// rtl/z_sync_fifo.sv - single-clock word FIFO with occupancy count
module z_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));
    assign count = cnt;

    // A push into a full FIFO still lands when the same edge frees a slot.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Empty FIFO presents zero so the output is defined straight out of reset.
    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/z_packer.sv
// rtl/z_packer.sv - packs {z1,z2} pairs four to a byte and buffers them in a FIFO
module z_packer
    import z_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    z_packer_if.slave    bus,
    output logic         overflow,
    output logic [7:0]   z1_count
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    pack_state_t       state, state_nx;
    logic [1:0]        idx, idx_nx;
    logic [WORD_W-1:0] word, word_nx;
    logic [WORD_W-1:0] assembled;
    logic [WORD_W-1:0] push_word;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;

    // Unfilled pair slots are always zero, so OR-ing the new pair in is enough.
    assign assembled = word | (WORD_W'({bus.z1, bus.z2}) << {idx, 1'b0});

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            idx   <= '0;
            word  <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            word  <= word_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        word_nx   = word;
        fifo_push = 1'b0;
        push_word = word;
        if (bus.in_valid) begin
            // A concurrent flush includes this pair before the word goes out.
            if (idx == 2'(PAIRS_PER_WORD - 1) || bus.flush) begin
                fifo_push = 1'b1;
                push_word = assembled;
                state_nx  = EMPTY;
                idx_nx    = '0;
                word_nx   = '0;
            end else begin
                state_nx  = PARTIAL;
                idx_nx    = idx + 2'd1;
                word_nx   = assembled;
            end
        end else if (bus.flush && state == PARTIAL) begin
            fifo_push = 1'b1;
            push_word = word;
            state_nx  = EMPTY;
            idx_nx    = '0;
            word_nx   = '0;
        end
    end

    assign fifo_pop = bus.out_ready & ~fifo_empty;

    z_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (push_word),
        .dout  (bus.out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.out_valid = ~fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (fifo_push && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z1_count <= '0;
        end else if (bus.in_valid && bus.z1 && z1_count != 8'hFF) begin
            z1_count <= z1_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_z_packer.sv
// tb/tb_z_packer.sv - vector table, corner sequences and random model check for z_packer
module tb_z_packer;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       overflow;
    logic [7:0] z1_count;

    z_packer_if zif();

    z_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (zif),
        .overflow (overflow),
        .z1_count (z1_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv, z1, z2, fl, rdy;
        logic       e_ov;
        logic [7:0] e_data;
        logic [7:0] e_cnt;
        logic       e_ovf;
    } vec_t;

    vec_t       tbl [19];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] popped [$];

    logic [7:0] m_q [$];
    logic [1:0] m_pairs [$];
    logic       m_ovf;
    int         m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic iv, input logic a, input logic b, input logic fl, input logic rdy);
        zif.in_valid  = iv;
        zif.z1        = a;
        zif.z2        = b;
        zif.flush     = fl;
        zif.out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        m_q.delete();
        m_pairs.delete();
        m_ovf = 1'b0;
        m_cnt = 0;
    endtask

    task automatic feed_word(input logic [7:0] w, input logic rdy_last);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, w[2*k+1], w[2*k], 1'b0, (k == 3) ? rdy_last : 1'b0);
        end
    endtask

    task automatic drain(output int n);
        n = 0;
        popped.delete();
        for (int i = 0; i < 12; i++) begin
            if (!zif.out_valid) break;
            popped.push_back(zif.out_data);
            n++;
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        zif.out_ready = 1'b0;
    endtask

    function automatic logic [7:0] build(input logic [1:0] p [$]);
        logic [7:0] w = 8'h00;
        for (int i = 0; i < p.size(); i++) w[2*i +: 2] = p[i];
        return w;
    endfunction

    // Reference behaviour for one clock edge, from the pair/word/FIFO rules.
    task automatic model_edge(input logic iv, input logic a, input logic b, input logic fl, input logic rdy);
        int         sz_before;
        logic       pop, push;
        logic [7:0] w;
        sz_before = m_q.size();
        pop  = (sz_before > 0) && rdy;
        push = 1'b0;
        w    = 8'h00;
        if (iv) begin
            m_pairs.push_back({a, b});
            if (a && m_cnt < 255) m_cnt++;
            if (m_pairs.size() == 4 || fl) begin
                push = 1'b1;
                w = build(m_pairs);
                m_pairs.delete();
            end
        end else if (fl && m_pairs.size() > 0) begin
            push = 1'b1;
            w = build(m_pairs);
            m_pairs.delete();
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (sz_before < DEPTH || pop) m_q.push_back(w);
            else m_ovf = 1'b1;
        end
    endtask

    initial begin
        int n;
        int phase_rdy;
        rst = 1'b1;
        zif.in_valid = 1'b0; zif.z1 = 1'b0; zif.z2 = 1'b0;
        zif.flush = 1'b0;    zif.out_ready = 1'b0;

        tbl[0]  = '{1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,8'h00,8'd0,1'b0};
        tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,8'h00,8'd0,1'b0};
        tbl[2]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,8'h00,8'd1,1'b0};
        tbl[3]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,8'hB1,8'd2,1'b0};
        tbl[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,8'h00,8'd2,1'b0};
        tbl[5]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,8'h00,8'd3,1'b0};
        tbl[6]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,8'h00,8'd4,1'b0};
        tbl[7]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,8'h00,8'd5,1'b0};
        tbl[8]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,8'h3F,8'd5,1'b0};
        tbl[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,8'h00,8'd5,1'b0};
        tbl[10] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,8'h00,8'd5,1'b0};
        tbl[11] = '{1'b1,1'b1,1'b0,1'b1,1'b0, 1'b1,8'h02,8'd6,1'b0};
        tbl[12] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,8'h00,8'd6,1'b0};
        tbl[13] = '{1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,8'h00,8'd6,1'b0};
        tbl[14] = '{1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,8'h00,8'd6,1'b0};
        tbl[15] = '{1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,8'h00,8'd6,1'b0};
        tbl[16] = '{1'b1,1'b1,1'b1,1'b1,1'b0, 1'b1,8'hD5,8'd7,1'b0};
        tbl[17] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,8'hD5,8'd7,1'b0};
        tbl[18] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,8'h00,8'd7,1'b0};

        do_reset();
        chk("reset_out_valid", 32'(zif.out_valid), 32'd0);
        chk("reset_out_data",  32'(zif.out_data),  32'd0);
        chk("reset_overflow",  32'(overflow),      32'd0);
        chk("reset_z1_count",  32'(z1_count),      32'd0);

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].iv, tbl[i].z1, tbl[i].z2, tbl[i].fl, tbl[i].rdy);
            chk($sformatf("vec%0d_out_valid", i), 32'(zif.out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("vec%0d_out_data", i),  32'(zif.out_data),  32'(tbl[i].e_data));
            chk($sformatf("vec%0d_z1_count", i),  32'(z1_count),      32'(tbl[i].e_cnt));
            chk($sformatf("vec%0d_overflow", i),  32'(overflow),      32'(tbl[i].e_ovf));
        end

        // Five words into a four-deep FIFO with no consumer.
        do_reset();
        for (int w = 0; w < 5; w++) feed_word(8'h00, 1'b0);
        chk("ovf_overflow_set", 32'(overflow),      32'd1);
        chk("ovf_out_valid",    32'(zif.out_valid), 32'd1);
        drain(n);
        chk("ovf_pop_count",    32'(n),             32'd4);
        chk("ovf_empty_after",  32'(zif.out_valid), 32'd0);
        chk("ovf_sticky",       32'(overflow),      32'd1);

        // Full FIFO, completing pair and a pop on the same edge.
        do_reset();
        feed_word(8'h00, 1'b0);
        feed_word(8'h55, 1'b0);
        feed_word(8'hAA, 1'b0);
        feed_word(8'hFF, 1'b0);
        chk("full_head", 32'(zif.out_data), 32'h00);
        feed_word(8'h1E, 1'b1);
        chk("full_pp_overflow", 32'(overflow),      32'd0);
        chk("full_pp_head",     32'(zif.out_data),  32'h55);
        drain(n);
        chk("full_pp_occupancy", 32'(n), 32'd4);
        if (n == 4) begin
            chk("full_pp_w1", 32'(popped[0]), 32'h55);
            chk("full_pp_w2", 32'(popped[1]), 32'hAA);
            chk("full_pp_w3", 32'(popped[2]), 32'hFF);
            chk("full_pp_w4", 32'(popped[3]), 32'h1E);
        end

        // Reset mid-word with a pair presented during reset.
        do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        chk("midrst_z1_count", 32'(z1_count),      32'd0);
        chk("midrst_out_valid", 32'(zif.out_valid), 32'd0);
        feed_word(8'h55, 1'b0);
        chk("midrst_word",     32'(zif.out_data),  32'h55);
        chk("midrst_valid",    32'(zif.out_valid), 32'd1);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("sat_z1_count", 32'(z1_count), 32'd255);

        // Random traffic against the reference model.
        do_reset();
        phase_rdy = 1;
        for (int c = 0; c < 1500; c++) begin
            logic iv, a, b, fl, rdy;
            if (c % 60 == 0) phase_rdy = (phase_rdy == 1) ? 5 : 1;
            iv  = ($urandom_range(0, 3) != 0);
            a   = 1'($urandom_range(0, 1));
            b   = 1'($urandom_range(0, 1));
            fl  = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 5) < phase_rdy);
            model_edge(iv, a, b, fl, rdy);
            step(iv, a, b, fl, rdy);
            chk("rnd_out_valid", 32'(zif.out_valid), 32'(m_q.size() > 0));
            chk("rnd_out_data",  32'(zif.out_data),  (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
            chk("rnd_overflow",  32'(overflow),      32'(m_ovf));
            chk("rnd_z1_count",  32'(z1_count),      32'(m_cnt));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/z_packer.md
Z_PACKER -- requirements
Module: z_packer

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, number of packed words buffered; power of two, at least 2.
REQ-002 Port: clk, input, 1, single clock; all state changes on the rising edge.
REQ-003 Port: rst, input, 1, reset; synchronous, active-high.
REQ-004 Port: in_valid, input, 1, the current {z1,z2} pair is to be captured this edge.
REQ-005 Port: z1, input, 1, upstream FSM output z1.
REQ-006 Port: z2, input, 1, upstream FSM output z2.
REQ-007 Port: flush, input, 1, emit the partial word, zero-padded.
REQ-008 Port: out_valid, output, 1, FIFO head word is available.
REQ-009 Port: out_ready, input, 1, consumer accepts the head word this edge.
REQ-010 Port: out_data, output, 8, FIFO head word.
REQ-011 Port: overflow, output, 1, sticky; a completed word was dropped.
REQ-012 Port: z1_count, output, 8, accepted pairs with z1=1; saturates at 255.

Function
REQ-013 Packing order SHALL be: pair k of a word (k=0..3, k=0 captured first) lands in out_data[2k+1:2k] as {z1,z2}.
REQ-014 The packer FSM SHALL have states EMPTY (0 pairs held) and PARTIAL (1-3 pairs held), with a 2-bit pair index.
REQ-015 Transitions: EMPTY->PARTIAL on in_valid; PARTIAL stays PARTIAL on in_valid while index<3; index 3 plus in_valid completes the word, pushes it and returns to EMPTY.
REQ-016 The packer SHALL hold state when in_valid=0 and flush=0.
REQ-017 flush in PARTIAL SHALL push the held pairs with unfilled bits zero and return to EMPTY; flush in EMPTY SHALL be a no-op (no zero word pushed).
REQ-018 flush and in_valid in the same cycle: the pair SHALL be included first, then the word pushed; a 4th pair plus flush pushes exactly one word.
REQ-019 Latency: a word pushed on edge N SHALL make out_valid=1 after edge N when the FIFO was empty; no combinational path from in_valid, z1, z2 or flush to out_valid or out_data.
REQ-020 Handshake: a pop occurs only on out_valid & out_ready; out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-021 Full with a push and no pop: the word SHALL be dropped, overflow set to 1 and held until rst, and the packer SHALL still return to EMPTY.
REQ-022 Full with push and pop on the same edge: both SHALL succeed; overflow SHALL remain unchanged.
REQ-023 Empty FIFO with out_ready=1 and no push: nothing changes; out_valid stays 0.
REQ-024 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an occupancy count of width log2(FIFO_DEPTH)+1.
REQ-025 z1_count SHALL increment by 1 per accepted pair with z1=1, hold at 255, and not count pairs captured while rst=1.

Reset
REQ-026 With rst=1 at an edge: FSM to EMPTY, index to 0, FIFO emptied, out_valid 0, out_data 0, overflow 0, z1_count 0.
REQ-027 Reset mid-word SHALL discard the held pairs; reset SHALL take priority over in_valid, flush and out_ready in the same cycle.

Structure
REQ-028 Package z_pkg SHALL hold WORD_W=8, PAIRS_PER_WORD=4, the packer state enum (EMPTY, PARTIAL) and the default FIFO_DEPTH.
REQ-029 The buffer SHALL be the sub-module z_sync_fifo (clk, rst, push, pop, din, dout, full, empty, count); z_packer contains the packer FSM, flush logic and counters.

Verification
REQ-030 After rst, in_valid=1 for 4 cycles with {z1,z2}=01,00,11,10 -> one cycle later out_valid=1, out_data=8'b10_11_00_01, z1_count=2.
REQ-031 3 pairs of 11, then flush -> out_data=8'b00_11_11_11; flush in EMPTY -> no push, out_valid stays 0.
REQ-032 out_ready=0, push 5 full words of 00 -> FIFO holds 4, overflow=1; then out_ready=1 -> exactly 4 pops, then out_valid=0.
REQ-033 FIFO full plus a completing pair and out_ready=1 on the same edge -> occupancy stays 4, overflow stays 0, popped word = oldest.
REQ-034 2 pairs captured, rst pulsed 1 cycle, then 4 pairs of 01 -> first word out = 8'b01_01_01_01 with no stale bits; 300 pairs of z1=1 -> z1_count=255.
